// File: rtl/perceptron_dot_engine_if.sv
// Request / response / branch-resolution bundle for perceptron_dot_engine.
// master = requester side (drives requests, consumes results, reports branches),
// slave  = engine side.
interface perceptron_dot_engine_if #(
   parameter int PERCEPTRON_NUMBER = 16,
   parameter int HISTORY_SIZE      = 8,
   parameter int WIDTH             = 8
);
   localparam int WEIGHT_NUMBER = HISTORY_SIZE + 1;
   localparam int SUM_W         = WIDTH + $clog2(WEIGHT_NUMBER) + 1;
   localparam int IDX_W         = $clog2(PERCEPTRON_NUMBER);

   logic                     req_valid;
   logic                     req_ready;
   logic [31:0]              req_pc;
   logic                     resp_valid;
   logic                     resp_ready;
   logic                     prediction;
   logic signed [SUM_W-1:0]  perceptron_output;
   logic                     needs_training;
   logic [IDX_W-1:0]         selected_perceptron;
   logic [HISTORY_SIZE-1:0]  resp_history;
   logic                     ex_valid;
   logic                     ex_mispredict;
   logic                     ex_outcome;
   logic [HISTORY_SIZE-1:0]  ex_history;

   modport master (
      output req_valid, req_pc, resp_ready,
             ex_valid, ex_mispredict, ex_outcome, ex_history,
      input  req_ready, resp_valid, prediction, perceptron_output,
             needs_training, selected_perceptron, resp_history
   );

   modport slave (
      input  req_valid, req_pc, resp_ready,
             ex_valid, ex_mispredict, ex_outcome, ex_history,
      output req_ready, resp_valid, prediction, perceptron_output,
             needs_training, selected_perceptron, resp_history
   );
endinterface

// File: rtl/perceptron_dot_engine.sv
// Multi-cycle perceptron dot product: bias plus LANES history-signed weights per
// cycle, speculative global history update on response, repair on mispredict.
module perceptron_dot_engine #(
   parameter int  PERCEPTRON_NUMBER = 16,
   parameter int  HISTORY_SIZE      = 8,
   parameter int  WIDTH             = 8,
   parameter int  LANES             = 4,
   localparam int WEIGHT_NUMBER     = HISTORY_SIZE + 1,
   localparam int SUM_W             = WIDTH + $clog2(WEIGHT_NUMBER) + 1,
   localparam int THRESHOLD         = (193 * HISTORY_SIZE + 1400) / 100
) (
   input  logic                    clk,
   input  logic                    rst,
   perceptron_dot_engine_if.slave  bus,
   input  logic signed [WIDTH-1:0] weights [PERCEPTRON_NUMBER][WEIGHT_NUMBER]
);
   localparam int IDX_W  = $clog2(PERCEPTRON_NUMBER);
   localparam int HIST_IW = $clog2(HISTORY_SIZE);
   localparam int WGT_IW  = $clog2(WEIGHT_NUMBER);
   localparam int CNT_W   = $clog2(HISTORY_SIZE + LANES + 1);

   localparam logic [CNT_W-1:0]      LANES_C  = LANES[CNT_W-1:0];
   localparam logic [CNT_W-1:0]      HIST_C   = HISTORY_SIZE[CNT_W-1:0];
   localparam logic signed [SUM_W:0] THRESH_W = THRESHOLD[SUM_W:0];

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t                   state, state_next;
   logic [HISTORY_SIZE-1:0]  ghr, ghr_next;
   logic signed [SUM_W-1:0]  acc, acc_next, lane_sum, bias_ext;
   logic [CNT_W-1:0]         cnt, cnt_next, cnt_step;
   logic [IDX_W-1:0]         index, index_next, pc_idx;
   logic [HISTORY_SIZE-1:0]  hist, hist_next;
   logic signed [WIDTH-1:0]  bias;
   logic signed [SUM_W:0]    acc_wide, acc_abs;
   logic                     repair, resp_pred;
   logic                     unused_pc;

   assign pc_idx    = bus.req_pc[IDX_W+1:2];
   assign unused_pc = ^{bus.req_pc[31:IDX_W+2], bus.req_pc[1:0]};
   assign repair    = bus.ex_valid && bus.ex_mispredict;
   assign cnt_step  = cnt + LANES_C;
   assign bias      = weights[pc_idx][0];
   assign bias_ext  = {{(SUM_W-WIDTH){bias[WIDTH-1]}}, bias};
   assign resp_pred = !acc[SUM_W-1];

   // One accumulation step: add or subtract up to LANES weights selected by history bits.
   always_comb begin
      logic [31:0]             pos;
      logic [31:0]             widx;
      logic signed [WIDTH-1:0] w;
      logic signed [SUM_W-1:0] term;
      lane_sum = acc;
      pos      = '0;
      widx     = '0;
      w        = '0;
      term     = '0;
      for (int unsigned j = 0; j < LANES; j++) begin
         pos  = 32'(cnt) + j;
         widx = pos + 32'd1;
         if (pos < HISTORY_SIZE) begin
            w    = weights[index][widx[WGT_IW-1:0]];
            term = {{(SUM_W-WIDTH){w[WIDTH-1]}}, w};
            if (hist[pos[HIST_IW-1:0]]) lane_sum = lane_sum + term;
            else                        lane_sum = lane_sum - term;
         end
      end
   end

   // Next-state logic; a mispredict repair overrides every other transition.
   always_comb begin
      state_next = state;
      ghr_next   = ghr;
      acc_next   = acc;
      cnt_next   = cnt;
      index_next = index;
      hist_next  = hist;
      if (repair) begin
         state_next = IDLE;
         ghr_next   = {bus.ex_history[HISTORY_SIZE-2:0], bus.ex_outcome};
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  index_next = pc_idx;
                  hist_next  = ghr;
                  acc_next   = bias_ext;
                  cnt_next   = '0;
                  state_next = ACCUM;
               end
            end
            ACCUM: begin
               acc_next = lane_sum;
               cnt_next = cnt_step;
               if (cnt_step >= HIST_C) state_next = DONE;
            end
            DONE: begin
               if (bus.resp_ready) begin
                  ghr_next   = {ghr[HISTORY_SIZE-2:0], resp_pred};
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         ghr   <= '0;
         acc   <= '0;
         cnt   <= '0;
         index <= '0;
         hist  <= '0;
      end else begin
         state <= state_next;
         ghr   <= ghr_next;
         acc   <= acc_next;
         cnt   <= cnt_next;
         index <= index_next;
         hist  <= hist_next;
      end
   end

   // Magnitude taken one bit wider so the most negative sum has a representable abs.
   always_comb begin
      acc_wide = {acc[SUM_W-1], acc};
      acc_abs  = acc_wide[SUM_W] ? -acc_wide : acc_wide;
   end

   assign bus.req_ready           = (state == IDLE);
   assign bus.resp_valid          = (state == DONE);
   assign bus.perceptron_output   = acc;
   assign bus.prediction          = bus.resp_valid && resp_pred;
   assign bus.needs_training      = bus.resp_valid && (acc_abs <= THRESH_W);
   assign bus.selected_perceptron = index;
   assign bus.resp_history        = hist;
endmodule

// File: tb/tb_perceptron_dot_engine.sv
// Scoreboard bench for perceptron_dot_engine: requests push model predictions,
// a negedge monitor pops and compares whenever a response is presented.
module tb_perceptron_dot_engine;
   localparam int PN    = 16;
   localparam int H     = 8;
   localparam int W     = 8;
   localparam int L     = 4;
   localparam int WN    = H + 1;
   localparam int SUM_W = W + $clog2(WN) + 1;
   localparam int IW    = $clog2(PN);
   localparam int THR   = (193 * H + 1400) / 100;
   localparam int LAT   = (H + L - 1) / L + 1;

   typedef struct {
      logic signed [SUM_W-1:0] out;
      logic                    pred;
      logic                    nt;
      logic [IW-1:0]           sel;
      logic [H-1:0]            hist;
      int unsigned             acc_cyc;
   } exp_t;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic signed [W-1:0] weights [PN][WN];

   exp_t        q[$];
   logic [H-1:0] ghr_m = '0;
   logic         busy = 1'b0;
   logic         first_seen = 1'b0;
   int unsigned  cyc = 0;
   int           tests = 0;
   int           fails = 0;

   perceptron_dot_engine_if #(.PERCEPTRON_NUMBER(PN), .HISTORY_SIZE(H), .WIDTH(W)) bus ();

   perceptron_dot_engine #(
      .PERCEPTRON_NUMBER(PN), .HISTORY_SIZE(H), .WIDTH(W), .LANES(L)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus), .weights(weights)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Dot product straight from the definition: bias plus +/- weight per history bit.
   function automatic exp_t model(input logic [31:0] pc, input logic [H-1:0] g, input int unsigned c);
      exp_t e;
      int   s;
      int   idx;
      int   mag;
      idx = int'((pc >> 2) % PN);
      s   = int'(weights[idx][0]);
      for (int j = 0; j < H; j++) begin
         if (g[j]) s = s + int'(weights[idx][j+1]);
         else      s = s - int'(weights[idx][j+1]);
      end
      e.out     = s[SUM_W-1:0];
      mag       = int'(e.out) < 0 ? -int'(e.out) : int'(e.out);
      e.pred    = int'(e.out) >= 0;
      e.nt      = mag <= THR;
      e.sel     = idx[IW-1:0];
      e.hist    = g;
      e.acc_cyc = c;
      return e;
   endfunction

   // Monitor: compares presented responses, tracks history and busy state.
   always @(negedge clk) begin
      logic rep;
      exp_t e;
      cyc++;
      if (rst) begin
         q.delete();
         ghr_m      = '0;
         busy       = 1'b0;
         first_seen = 1'b0;
      end else begin
         rep = bus.ex_valid && bus.ex_mispredict;
         chk("req_ready", longint'(bus.req_ready), longint'(!busy));
         if (bus.resp_valid) begin
            if (q.size() == 0) begin
               chk("unexpected_resp_valid", 1, 0);
            end else begin
               e = q[0];
               if (!first_seen) begin
                  chk("latency", longint'(cyc - e.acc_cyc), LAT);
                  first_seen = 1'b1;
               end
               chk("perceptron_output", bus.perceptron_output, e.out);
               chk("prediction", bus.prediction, e.pred);
               chk("needs_training", bus.needs_training, e.nt);
               chk("selected_perceptron", bus.selected_perceptron, e.sel);
               chk("resp_history", bus.resp_history, e.hist);
               if (bus.resp_ready) begin
                  void'(q.pop_front());
                  first_seen = 1'b0;
                  busy       = 1'b0;
                  if (!rep) ghr_m = {ghr_m[H-2:0], e.pred};
               end
            end
         end
         if (rep) begin
            q.delete();
            busy       = 1'b0;
            first_seen = 1'b0;
            ghr_m      = {bus.ex_history[H-2:0], bus.ex_outcome};
         end else if (bus.req_valid && bus.req_ready) begin
            q.push_back(model(bus.req_pc, ghr_m, cyc));
            busy = 1'b1;
         end
      end
   end

   task automatic send_req(input logic [31:0] pc);
      int unsigned n = 0;
      bus.req_valid = 1'b1;
      bus.req_pc    = pc;
      @(negedge clk);
      while (!bus.req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) chk("req_accept_timeout", 0, 1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_valid();
      int unsigned n = 0;
      while (!bus.resp_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.resp_valid) chk("resp_valid_timeout", 0, 1);
   endtask

   task automatic wait_resp(input int unsigned stall, output longint o, output logic p,
                            output logic nt, output logic [H-1:0] h);
      bus.resp_ready = 1'b0;
      wait_valid();
      o  = bus.perceptron_output;
      p  = bus.prediction;
      nt = bus.needs_training;
      h  = bus.resp_history;
      repeat (stall) begin
         @(posedge clk); #1;
      end
      bus.resp_ready = 1'b1;
      @(posedge clk); #1;
      bus.resp_ready = 1'b0;
   endtask

   task automatic repair(input logic [H-1:0] h, input logic o);
      bus.ex_valid      = 1'b1;
      bus.ex_mispredict = 1'b1;
      bus.ex_history    = h;
      bus.ex_outcome    = o;
      @(posedge clk); #1;
      bus.ex_valid      = 1'b0;
      bus.ex_mispredict = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, bus.req_ready, 1);
      chk({tag, "_resp_valid"}, bus.resp_valid, 0);
      chk({tag, "_prediction"}, bus.prediction, 0);
      chk({tag, "_perceptron_output"}, bus.perceptron_output, 0);
      chk({tag, "_needs_training"}, bus.needs_training, 0);
      chk({tag, "_selected"}, bus.selected_perceptron, 0);
      chk({tag, "_resp_history"}, bus.resp_history, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      longint       o;
      logic         p, nt;
      logic [H-1:0] h;
      logic [31:0]  r;

      bus.req_valid     = 1'b0;
      bus.req_pc        = '0;
      bus.resp_ready    = 1'b0;
      bus.ex_valid      = 1'b0;
      bus.ex_mispredict = 1'b0;
      bus.ex_outcome    = 1'b0;
      bus.ex_history    = '0;
      for (int i = 0; i < PN; i++)
         for (int j = 0; j < WN; j++) weights[i][j] = '0;

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("por");
      rst = 1'b0;
      @(posedge clk); #1;

      // All-zero weights: sum 0 is TAKEN and inside the training margin.
      send_req(32'h40);
      wait_resp(0, o, p, nt, h);
      chk("zero_output", o, 0);
      chk("zero_prediction", p, 1);
      chk("zero_needs_training", nt, 1);

      // bias 5, weights +10, all-taken history.
      weights[5][0] = 8'sd5;
      for (int j = 1; j < WN; j++) weights[5][j] = 8'sd10;
      repair(8'h7F, 1'b1);
      send_req(32'h14);
      wait_resp(0, o, p, nt, h);
      chk("ones_output", o, 85);
      chk("ones_prediction", p, 1);
      chk("ones_needs_training", nt, 0);
      chk("ones_history", h, 8'hFF);

      // Same weights, all-not-taken history.
      repair(8'h00, 1'b0);
      send_req(32'h14);
      wait_resp(0, o, p, nt, h);
      chk("zeros_output", o, -75);
      chk("zeros_prediction", p, 0);
      chk("zeros_needs_training", nt, 0);

      // Stalled consumer for 5 cycles; history must still be 0x00 from the shift of 0.
      send_req(32'h14);
      wait_resp(5, o, p, nt, h);
      chk("stall_history", h, 8'h00);
      chk("stall_output", o, -75);

      // Mispredict during accumulation discards the result and rewrites history.
      send_req(32'h14);
      repair(8'h0F, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      send_req(32'h40);
      wait_resp(0, o, p, nt, h);
      chk("repair_history", h, 8'h1F);

      // Reset pulse mid-accumulation.
      send_req(32'h14);
      #1;
      rst = 1'b1;
      #1;
      check_reset_outputs("mid_rst");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      send_req(32'h40);
      wait_resp(0, o, p, nt, h);
      chk("post_rst_history", h, 8'h00);

      // Repair and new request in the same cycle: request is not taken.
      bus.req_valid = 1'b1;
      bus.req_pc    = 32'h14;
      repair(8'h55, 1'b1);
      bus.req_valid = 1'b0;
      @(posedge clk); #1;
      send_req(32'h40);
      wait_resp(0, o, p, nt, h);
      chk("req_vs_repair_history", h, 8'hAB);

      // Repair coincident with response handshake: consumed, no speculative shift.
      send_req(32'h14);
      wait_valid();
      bus.resp_ready = 1'b1;
      repair(8'h33, 1'b0);
      bus.resp_ready = 1'b0;
      @(posedge clk); #1;
      send_req(32'h40);
      wait_resp(0, o, p, nt, h);
      chk("resp_vs_repair_history", h, 8'h66);

      // Randomized traffic.
      for (int t = 0; t < 150; t++) begin
         if ($urandom_range(3, 0) == 0) begin
            for (int i = 0; i < PN; i++)
               for (int j = 0; j < WN; j++) begin
                  r = $urandom;
                  weights[i][j] = r[W-1:0];
               end
         end
         if ($urandom_range(4, 0) == 0) begin
            r = $urandom;
            repair(r[H-1:0], r[8]);
         end
         r = $urandom;
         send_req(r);
         if ($urandom_range(9, 0) == 0) begin
            r = $urandom;
            repair(r[H-1:0], r[8]);
            @(posedge clk); #1;
         end else begin
            if ($urandom_range(4, 0) == 0) begin
               r = $urandom;
               bus.ex_valid   = 1'b1;
               bus.ex_history = r[H-1:0];
               bus.ex_outcome = r[8];
               @(posedge clk); #1;
               bus.ex_valid = 1'b0;
            end
            wait_resp($urandom_range(3, 0), o, p, nt, h);
         end
      end

      repeat (5) @(posedge clk);
      #1;
      chk("queue_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/perceptron_dot_engine.md
PERCEPTRON_DOT_ENGINE -- requirements
Module: perceptron_dot_engine

Interface
REQ-001 SHALL have parameter PERCEPTRON_NUMBER, default 16, the perceptron count (power of 2).
REQ-002 SHALL have parameter HISTORY_SIZE, default 8, the global history length H.
REQ-003 SHALL have parameter WIDTH, default 8, the signed weight width.
REQ-004 SHALL have parameter LANES, default 4, the weights summed per cycle (1..H).
REQ-005 SHALL derive WEIGHT_NUMBER = H+1 (index 0 = bias), SUM_W = WIDTH+$clog2(WEIGHT_NUMBER)+1, and THRESHOLD = (193*H+1400)/100 (integer).
REQ-006 SHALL have ports as follows, one clock and reset asynchronous active-high:
 clk  in  1  clock
 rst  in  1  asynchronous active-high reset
 req_valid  in  1  prediction request
 req_ready  out  1  engine can accept
 req_pc  in  32  branch PC
 weights  in  signed WIDTH x [PERCEPTRON_NUMBER][WEIGHT_NUMBER]  live weight table
 resp_valid  out  1  result available
 resp_ready  in  1  consumer accepts result
 prediction  out  1  1 = TAKEN
 perceptron_output  out  signed SUM_W  dot product
 needs_training  out  1  |perceptron_output| <= THRESHOLD
 selected_perceptron  out  $clog2(PERCEPTRON_NUMBER)  index used
 resp_history  out  H  history snapshot used
 ex_valid  in  1  resolved branch
 ex_mispredict  in  1  resolved branch was mispredicted
 ex_outcome  in  1  actual direction
 ex_history  in  H  snapshot the resolved branch was predicted with

Function
REQ-007 SHALL implement FSM IDLE, ACCUM, DONE; req_ready = 1 only in IDLE; resp_valid = 1 only in DONE.
REQ-008 SHALL on req_valid && req_ready: latch index = req_pc[$clog2(PERCEPTRON_NUMBER)+1:2], snapshot GHR into resp_history, acc = sign-extended weights[index][0], cnt = 0, go ACCUM.
REQ-009 SHALL in each ACCUM cycle add, for j = cnt..min(cnt+LANES,H)-1, +weights[index][j+1] if resp_history[j] else -weights[index][j+1], reading weights live that cycle; cnt += LANES.
REQ-010 SHALL go DONE in the cycle cnt+LANES >= H; latency accept-to-resp_valid = ceil(H/LANES)+1 cycles.
REQ-011 SHALL keep all sums at SUM_W signed bits, sign-extended, no saturation; the abs for needs_training SHALL be computed at SUM_W+1 bits.
REQ-012 SHALL drive prediction = (perceptron_output >= 0); all resp outputs stable while resp_valid && !resp_ready.
REQ-013 SHALL on resp_valid && resp_ready: GHR <= {GHR[H-2:0], prediction}, FSM -> IDLE.
REQ-014 SHALL on ex_valid && ex_mispredict: GHR <= {ex_history[H-2:0], ex_outcome}, FSM -> IDLE next cycle, in-flight result discarded.
REQ-015 SHALL give repair (REQ-014) priority over speculative shift and over a new request in the same cycle; a coincident response handshake counts as consumed but does not shift GHR.
REQ-016 SHALL ignore ex_valid without ex_mispredict.

Reset
REQ-017 SHALL on rst, asynchronously: FSM = IDLE, GHR = 0, acc = 0, cnt = 0, index = 0, resp_history = 0.
REQ-018 SHALL hold outputs during reset as req_ready = 1, resp_valid = 0, prediction = 0, perceptron_output = 0, needs_training = 0, selected_perceptron = 0, resp_history = 0.
REQ-019 SHALL abandon any computation when reset asserts mid-operation; no response is produced for it.

Verification
REQ-020 SHALL cover: all weights 0, req_pc = 0x40 -> selected 0, resp_valid 3 cycles after accept, output 0, prediction 1, needs_training 1.
REQ-021 SHALL cover: bias = 5, w1..w8 = +10, GHR = 0xFF -> output 85, prediction 1, needs_training 0 (THRESHOLD = 29).
REQ-022 SHALL cover: same weights, GHR = 0x00 -> output -75, prediction 0, needs_training 0; after handshake GHR = 0x00.
REQ-023 SHALL cover: resp_ready low 5 cycles in DONE -> outputs stable, req_ready 0, GHR unchanged until handshake.
REQ-024 SHALL cover: mispredict during ACCUM with ex_history = 0x0F, ex_outcome = 1 -> GHR = 0x1F, no resp_valid, req_ready 1 next cycle.
REQ-025 SHALL cover: rst pulse mid-ACCUM -> outputs at reset values immediately, GHR = 0.
